imm_gen_stage: RTL and testbench

- Registered, parametrised immediate generator for the ID stage. Covers every RV32I/RV64I immediate format: I (ALU, load, JALR), S, B, U and J, plus shift-amount immediates.
- Per instruction it produces the sign-extended immediate, a format tag, an unknown-opcode flag and, optionally, the PC-relative target pc + imm.
- A 2-entry skid buffer gives it valid/ready handshakes on both sides, so the stage can sit between IF/ID and ID/EX under backpressure without dropping or duplicating instructions.

---
 rtl/imm_gen_stage.sv | 165 ++++++++++++++++
 tb/tb_imm_gen_stage.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_stage.sv
// Registered RV32I/RV64I immediate generator with a 2-entry skid buffer.
// Decode is combinational on the input side; main/skid registers give valid/ready on both sides.
module imm_gen_stage #(
  parameter int XLEN      = 32,
  parameter bit EN_TARGET = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst_code,
  input  logic [XLEN-1:0] pc_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] Imm_out,
  output logic [2:0]      imm_type,
  output logic            unknown,
  output logic [XLEN-1:0] target_out,
  output logic [XLEN-1:0] pc_out
);

  typedef enum logic [2:0] {
    IMM_NONE  = 3'd0,
    IMM_I     = 3'd1,
    IMM_S     = 3'd2,
    IMM_B     = 3'd3,
    IMM_U     = 3'd4,
    IMM_J     = 3'd5,
    IMM_SHAMT = 3'd6
  } imm_type_e;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      kind;
    logic            unk;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pc;
  } entry_t;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // in_ready is registered (= !skid full), so it never depends on out_ready combinationally.

  logic [31:0]     imm32;
  logic [XLEN-1:0] imm_ext;
  imm_type_e       kind;
  logic            unk;
  logic [2:0]      funct3;
  entry_t          dec;

  assign funct3 = inst_code[14:12];

  // Every format fits in a signed 32-bit value; widen to XLEN at the end.
  always_comb begin
    imm32 = '0;
    kind  = IMM_NONE;
    unk   = 1'b0;
    case (inst_code[6:0])
      7'b0010011: begin
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          kind  = IMM_SHAMT;
          imm32 = (XLEN == 64) ? {26'b0, inst_code[25:20]} : {27'b0, inst_code[24:20]};
        end else begin
          kind  = IMM_I;
          imm32 = {{20{inst_code[31]}}, inst_code[31:20]};
        end
      end
      7'b0000011, 7'b1100111: begin
        kind  = IMM_I;
        imm32 = {{20{inst_code[31]}}, inst_code[31:20]};
      end
      7'b0100011: begin
        kind  = IMM_S;
        imm32 = {{20{inst_code[31]}}, inst_code[31:25], inst_code[11:7]};
      end
      7'b1100011: begin
        kind  = IMM_B;
        imm32 = {{19{inst_code[31]}}, inst_code[31], inst_code[7], inst_code[30:25],
                 inst_code[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        kind  = IMM_U;
        imm32 = {inst_code[31:12], 12'b0};
      end
      7'b1101111: begin
        kind  = IMM_J;
        imm32 = {{11{inst_code[31]}}, inst_code[31], inst_code[19:12], inst_code[20],
                 inst_code[30:21], 1'b0};
      end
      7'b0110011, 7'b1110011, 7'b0001111: kind = IMM_NONE;
      default: unk = 1'b1;
    endcase
  end

  assign imm_ext    = XLEN'($signed(imm32));
  assign dec.imm    = imm_ext;
  assign dec.kind   = kind;
  assign dec.unk    = unk;
  assign dec.target = EN_TARGET ? (pc_in + imm_ext) : '0;
  assign dec.pc     = pc_in;

  entry_t main_q, main_d, skid_q, skid_d;
  logic   main_valid_q, main_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   in_ready_q, in_ready_d;
  logic   in_hs, out_hs;

  assign in_hs  = in_valid & in_ready_q;
  assign out_hs = main_valid_q & out_ready;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_hs) begin
      // in_hs cannot coincide with a full skid, so skid refill has priority here.
      if (skid_valid_q) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end else if (in_hs) begin
        main_d = dec;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (in_hs) begin
      if (!main_valid_q) begin
        main_d       = dec;
        main_valid_d = 1'b1;
      end else begin
        skid_d       = dec;
        skid_valid_d = 1'b1;
      end
    end
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = main_valid_q;
  assign Imm_out    = main_q.imm;
  assign imm_type   = main_q.kind;
  assign unknown    = main_q.unk;
  assign target_out = main_q.target;
  assign pc_out     = main_q.pc;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: decode table, backpressure/flush/reset sequences and a
// randomized stream checked against an arithmetic reference model through a scoreboard.
module tb_imm_gen_stage;

  localparam int EW = 100;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic        in_valid, in_ready;
  logic [31:0] inst_code, pc_in;
  logic        out_valid, out_ready;
  logic [31:0] Imm_out, target_out, pc_out;
  logic [2:0]  imm_type;
  logic        unknown;

  logic        in_valid64, in_ready64, out_valid64, out_ready64, unknown64;
  logic [31:0] inst64;
  logic [63:0] pc64, imm64_o, target64_o, pc64_o;
  logic [2:0]  imm_type64;

  logic rand_ready, ready_fix, rr;
  assign out_ready = rand_ready ? rr : ready_fix;

  int checks = 0;
  int errors = 0;
  int in_cnt = 0;
  int out_cnt = 0;
  bit sb_en = 1'b0;
  logic [EW-1:0] exp_q[$];

  imm_gen_stage #(.XLEN(32), .EN_TARGET(1'b1)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .inst_code(inst_code), .pc_in(pc_in),
    .out_valid(out_valid), .out_ready(out_ready), .Imm_out(Imm_out), .imm_type(imm_type),
    .unknown(unknown), .target_out(target_out), .pc_out(pc_out)
  );

  imm_gen_stage #(.XLEN(64), .EN_TARGET(1'b1)) dut64 (
    .clk(clk), .reset(reset), .flush(1'b0),
    .in_valid(in_valid64), .in_ready(in_ready64), .inst_code(inst64), .pc_in(pc64),
    .out_valid(out_valid64), .out_ready(out_ready64), .Imm_out(imm64_o), .imm_type(imm_type64),
    .unknown(unknown64), .target_out(target64_o), .pc_out(pc64_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    longint imm;
    int     kind;
    bit     unk;
  } ref_t;

  // Two's-complement weighting: the sign bit contributes a negative power of two.
  function automatic ref_t ref_decode(input logic [31:0] inst, input int xlen);
    ref_t   r;
    longint s;
    s = inst[31] ? 64'sd1 : 64'sd0;
    r.imm = 0; r.kind = 0; r.unk = 1'b0;
    case (inst[6:0])
      7'b0010011: begin
        if (inst[14:12] == 3'b001 || inst[14:12] == 3'b101) begin
          r.kind = 6;
          r.imm  = (xlen == 64) ? longint'(inst[25:20]) : longint'(inst[24:20]);
        end else begin
          r.kind = 1;
          r.imm  = longint'(inst[30:20]) - s * 2048;
        end
      end
      7'b0000011, 7'b1100111: begin
        r.kind = 1;
        r.imm  = longint'(inst[30:20]) - s * 2048;
      end
      7'b0100011: begin
        r.kind = 2;
        r.imm  = longint'(inst[30:25]) * 32 + longint'(inst[11:7]) - s * 2048;
      end
      7'b1100011: begin
        r.kind = 3;
        r.imm  = longint'(inst[7]) * 2048 + longint'(inst[30:25]) * 32
               + longint'(inst[11:8]) * 2 - s * 4096;
      end
      7'b0110111, 7'b0010111: begin
        r.kind = 4;
        r.imm  = longint'(inst[30:12]) * 4096 - s * 64'sd2147483648;
      end
      7'b1101111: begin
        r.kind = 5;
        r.imm  = longint'(inst[19:12]) * 4096 + longint'(inst[20]) * 2048
               + longint'(inst[30:21]) * 2 - s * 1048576;
      end
      7'b0110011, 7'b1110011, 7'b0001111: r.kind = 0;
      default: r.unk = 1'b1;
    endcase
    return r;
  endfunction

  function automatic logic [EW-1:0] exp32(input logic [31:0] inst, input logic [31:0] pc);
    ref_t        r;
    logic [31:0] i32;
    logic [2:0]  k;
    r   = ref_decode(inst, 32);
    i32 = r.imm[31:0];
    k   = r.kind[2:0];
    return {i32, k, r.unk, pc + i32, pc};
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    logic [6:0]  op;
    logic [6:0]  ops [11];
    ops = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h73, 7'h0F};
    r = $urandom();
    if ($urandom_range(0, 11) == 11) op = 7'($urandom_range(0, 127));
    else op = ops[$urandom_range(0, 10)];
    return {r[31:7], op};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard (sampled on the falling edge) ----------------
  logic [EW-1:0] act_v, held;
  bit            hold_pending = 1'b0;
  assign act_v = {Imm_out, imm_type, unknown, target_out, pc_out};

  always @(negedge clk) begin
    if (!sb_en) begin
      hold_pending = 1'b0;
    end else if (flush) begin
      exp_q.delete();
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) chk("stable", {out_valid, act_v}, {1'b1, held});
      if (in_valid && in_ready) begin
        exp_q.push_back(exp32(inst_code, pc_in));
        in_cnt++;
      end
      if (out_valid && out_ready) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_extra: got %0h expected nothing", act_v);
        end else begin
          chk("sb_out", act_v, exp_q.pop_front());
        end
      end
      hold_pending = out_valid && !out_ready;
      held         = act_v;
    end
  end

  always @(posedge clk) begin
    #1;
    rr = ($urandom_range(0, 3) != 0);
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [31:0] inst, input logic [31:0] pc);
    bit acc = 1'b0;
    int n = 0;
    inst_code = inst; pc_in = pc; in_valid = 1'b1;
    while (!acc && n < 200) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1; n++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++; errors++;
      $display("FAIL send_timeout: got no in_ready after %0d cycles expected accept", n);
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  // ---------------- test ----------------
  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [2:0]  kind;
    logic        unk;
    logic [31:0] target;
  } vec_t;

  vec_t tab [11];

  initial begin
    tab[0]  = '{32'hFFF00093, 32'h0000_0000, 32'hFFFF_FFFF, 3'd1, 1'b0, 32'hFFFF_FFFF};
    tab[1]  = '{32'h4030D093, 32'h0000_0100, 32'h0000_0003, 3'd6, 1'b0, 32'h0000_0103};
    tab[2]  = '{32'hFE000EE3, 32'h0000_1000, 32'hFFFF_FFFC, 3'd3, 1'b0, 32'h0000_0FFC};
    tab[3]  = '{32'h123450B7, 32'h0000_0000, 32'h1234_5000, 3'd4, 1'b0, 32'h1234_5000};
    tab[4]  = '{32'h010000EF, 32'hFFFF_FFF8, 32'h0000_0010, 3'd5, 1'b0, 32'h0000_0008};
    tab[5]  = '{32'h0000007F, 32'h0000_0044, 32'h0000_0000, 3'd0, 1'b1, 32'h0000_0044};
    tab[6]  = '{32'h00000033, 32'h0000_0020, 32'h0000_0000, 3'd0, 1'b0, 32'h0000_0020};
    tab[7]  = '{32'hFE112E23, 32'h0000_0010, 32'hFFFF_FFFC, 3'd2, 1'b0, 32'h0000_000C};
    tab[8]  = '{32'h80002003, 32'h0000_0800, 32'hFFFF_F800, 3'd1, 1'b0, 32'h0000_0000};
    tab[9]  = '{32'h7FF000E7, 32'h0000_0000, 32'h0000_07FF, 3'd1, 1'b0, 32'h0000_07FF};
    tab[10] = '{32'h03F09093, 32'h0000_0000, 32'h0000_001F, 3'd6, 1'b0, 32'h0000_001F};

    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; inst_code = '0; pc_in = '0;
    rand_ready = 1'b0; ready_fix = 1'b0;
    in_valid64 = 1'b0; inst64 = '0; pc64 = '0; out_ready64 = 1'b0;
    #1 reset = 1'b1;
    #2;
    chk("rst_async", {out_valid, in_ready, act_v}, '0);
    #6;
    chk("rst_held", {out_valid, in_ready, act_v}, '0);
    chk("rst_64", {out_valid64, in_ready64, imm64_o, target64_o, pc64_o}, '0);
    #4 reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_ready64", in_ready64, 1'b1);

    // decode table, one per cycle, each row visible one cycle later
    ready_fix = 1'b1;
    for (int i = 0; i < 11; i++) begin
      inst_code = tab[i].inst; pc_in = tab[i].pc; in_valid = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("tab%0d_valid", i), {out_valid, in_ready}, 2'b11);
      chk($sformatf("tab%0d_imm", i), Imm_out, tab[i].imm);
      chk($sformatf("tab%0d_type", i), {imm_type, unknown}, {tab[i].kind, tab[i].unk});
      chk($sformatf("tab%0d_tgt", i), {target_out, pc_out}, {tab[i].target, tab[i].pc});
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("tab_empty", out_valid, 1'b0);

    // backpressure: third instruction must wait for the skid to empty
    sb_en = 1'b1; ready_fix = 1'b0;
    inst_code = 32'h00500093; pc_in = 32'h200; in_valid = 1'b1;
    @(posedge clk); #1;
    chk("bp_first", {out_valid, in_ready}, 2'b11);
    inst_code = 32'hFE112E23; pc_in = 32'h204;
    @(posedge clk); #1;
    chk("bp_full", in_ready, 1'b0);
    chk("bp_hold_imm", Imm_out, 32'h5);
    inst_code = 32'h123450B7; pc_in = 32'h208;
    @(posedge clk); #1;
    chk("bp_blocked", {out_valid, in_ready, Imm_out}, {2'b10, 32'h5});
    ready_fix = 1'b1;
    begin
      bit acc = 1'b0;
      int n = 0;
      while (!acc && n < 20) begin
        @(negedge clk); acc = in_ready;
        @(posedge clk); #1; n++;
      end
      in_valid = 1'b0;
      chk("bp_third_accepted", acc, 1'b1);
    end
    drain("bp_drain");
    chk("bp_count", {in_cnt, out_cnt}, {32'd3, 32'd3});
    chk("bp_ready_back", in_ready, 1'b1);

    // random valid/ready stream
    rand_ready = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      send(rand_inst(), $urandom());
    end
    rand_ready = 1'b0;
    drain("rnd_drain");
    chk("rnd_count", {in_cnt, out_cnt}, {32'd10003, 32'd10003});

    // flush with both entries full and a new instruction offered
    ready_fix = 1'b0;
    send(32'h00100093, 32'h300);
    send(32'h00200093, 32'h304);
    chk("fl_full", {out_valid, in_ready}, 2'b10);
    inst_code = 32'h00300093; pc_in = 32'h308; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_cleared", {out_valid, in_ready}, 2'b01);
    ready_fix = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("fl_gone%0d", i), out_valid, 1'b0);
    end
    chk("fl_queue", exp_q.size(), 0);

    // XLEN=64 decode
    out_ready64 = 1'b1;
    inst64 = 32'h03F09093; pc64 = 64'h1000; in_valid64 = 1'b1;
    @(posedge clk); #1;
    chk("x64_shamt", {out_valid64, imm_type64, imm64_o}, {1'b1, 3'd6, 64'h3F});
    inst64 = 32'h800000B7; pc64 = 64'h0;
    @(posedge clk); #1;
    chk("x64_u_sext", {imm_type64, imm64_o}, {3'd4, 64'hFFFF_FFFF_8000_0000});
    for (int i = 0; i < 200; i++) begin
      ref_t r;
      logic [63:0] e;
      inst64 = rand_inst(); pc64 = {$urandom(), $urandom()};
      r = ref_decode(inst64, 64);
      e = r.imm;
      @(posedge clk); #1;
      chk("x64_rnd", {imm64_o, imm_type64, unknown64, target64_o, pc64_o},
          {e, r.kind[2:0], r.unk, pc64 + e, pc64});
    end
    out_ready64 = 1'b0;

    // asynchronous reset between edges, both instances holding data
    inst_code = 32'h00700093; pc_in = 32'h400; in_valid = 1'b1;
    @(posedge clk); #3;
    chk("mr_pre", {out_valid, out_valid64}, 2'b11);
    sb_en = 1'b0;
    reset = 1'b1;
    #1;
    chk("mr_zero", {out_valid, in_ready, act_v}, '0);
    chk("mr_zero64", {out_valid64, in_ready64, imm64_o, imm_type64, unknown64, target64_o, pc64_o}, '0);
    exp_q.delete();
    in_valid = 1'b0;
    @(posedge clk); #2;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("mr_ready", {in_ready, in_ready64, out_valid, out_valid64}, 4'b1100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
